muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer for the execute stage. Accepts one RV64M operation (MUL, MULW, DIV, DIVW, DIVU, DIVUW, REM, REMW, REMU, REMUW), runs a shift-add multiplier or a restoring divider over 32 or 64 cycles, and returns the result with a single-cycle `done`. While the operation runs it holds the pipeline through `stall`, which the hazard unit turns into STALLE. A flush from a later stage abandons the operation.

---
 rtl/muldiv_seq.sv | 209 ++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV64M multiply/divide sequencer for the execute stage.
// Ports: clk, reset, valid, op, srca, srcb, flush -> stall, done, result.
package common;
  typedef logic [63:0] word_t;
  typedef logic [7:0]  decode_op_t;
  localparam decode_op_t OP_MUL   = 8'h01;
  localparam decode_op_t OP_MULW  = 8'h02;
  localparam decode_op_t OP_DIV   = 8'h03;
  localparam decode_op_t OP_DIVW  = 8'h04;
  localparam decode_op_t OP_DIVU  = 8'h05;
  localparam decode_op_t OP_DIVUW = 8'h06;
  localparam decode_op_t OP_REM   = 8'h07;
  localparam decode_op_t OP_REMW  = 8'h08;
  localparam decode_op_t OP_REMU  = 8'h09;
  localparam decode_op_t OP_REMUW = 8'h0A;
endpackage

module muldiv_seq
  import common::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  decode_op_t op,
  input  word_t      srca,
  input  word_t      srcb,
  input  logic       flush,
  output logic       stall,
  output logic       done,
  output word_t      result
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state_q, state_d;
  logic [5:0] count_q, count_d;
  word_t      acc_q, acc_d;
  word_t      a_q, a_d;
  word_t      b_q, b_d;
  word_t      result_q, result_d;
  logic       mul_q, mul_d;
  logic       w_q, w_d;
  logic       rem_q, rem_d;
  logic       negq_q, negq_d;
  logic       negr_q, negr_d;

  function automatic word_t sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  logic dec_m, dec_mul, dec_w, dec_sgn, dec_rem;

  always_comb begin
    dec_m   = 1'b1;
    dec_mul = 1'b0;
    dec_w   = 1'b0;
    dec_sgn = 1'b0;
    dec_rem = 1'b0;
    unique case (op)
      OP_MUL:   dec_mul = 1'b1;
      OP_MULW:  begin dec_mul = 1'b1; dec_w = 1'b1; end
      OP_DIV:   dec_sgn = 1'b1;
      OP_DIVW:  begin dec_sgn = 1'b1; dec_w = 1'b1; end
      OP_DIVU:  begin end
      OP_DIVUW: dec_w = 1'b1;
      OP_REM:   begin dec_sgn = 1'b1; dec_rem = 1'b1; end
      OP_REMW:  begin
        dec_sgn = 1'b1; dec_rem = 1'b1; dec_w = 1'b1;
      end
      OP_REMU:  dec_rem = 1'b1;
      OP_REMUW: begin dec_rem = 1'b1; dec_w = 1'b1; end
      default:  dec_m = 1'b0;
    endcase
  end

  word_t a_ext, b_ext, a_mag, b_mag, fast_res;
  logic  a_neg, b_neg, div0, ovf, fast;

  always_comb begin
    a_ext = srca;
    b_ext = srcb;
    if (dec_w) begin
      a_ext = dec_sgn ? sext32(srca[31:0])
                      : {32'b0, srca[31:0]};
      b_ext = dec_sgn ? sext32(srcb[31:0])
                      : {32'b0, srcb[31:0]};
    end
    a_neg = dec_sgn && a_ext[63];
    b_neg = dec_sgn && b_ext[63];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
    div0  = (b_ext == '0);
    ovf   = dec_sgn && (b_ext == '1) &&
            (a_ext == (dec_w ? 64'hFFFF_FFFF_8000_0000
                             : 64'h8000_0000_0000_0000));
    fast_res = '0;
    if (dec_m && div0)
      fast_res = dec_rem ? a_ext : '1;
    else if (dec_m && ovf)
      fast_res = dec_rem ? '0 : a_ext;
    // REMUW by zero still returns the sign-extended 32-bit dividend
    if (dec_m && div0 && dec_rem && dec_w)
      fast_res = sext32(srca[31:0]);
    fast = !dec_m || (!dec_mul && (div0 || ovf));
  end

  // Restoring step: shifted partial remainder needs 65 bits
  logic [64:0] trial, diff;
  logic        qbit;
  word_t       raw;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    mul_d    = mul_q;
    w_d      = w_q;
    rem_d    = rem_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    trial    = {acc_q, a_q[63]};
    diff     = trial - {1'b0, b_q};
    qbit     = ~diff[64];
    raw      = '0;
    unique case (state_q)
      IDLE: if (valid && !flush) begin
        mul_d   = dec_mul;
        w_d     = dec_w;
        rem_d   = dec_rem;
        negq_d  = a_neg ^ b_neg;
        negr_d  = a_neg;
        acc_d   = '0;
        count_d = '0;
        // W dividends sit in the top half so the MSB is always bit 63
        if (dec_mul) a_d = a_ext;
        else if (dec_w) a_d = {a_mag[31:0], 32'b0};
        else a_d = a_mag;
        b_d = dec_mul ? b_ext : b_mag;
        if (fast) begin
          state_d  = DONE;
          result_d = fast_res;
        end else begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mul_q) begin
          acc_d = b_q[0] ? acc_q + a_q : acc_q;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
        end else begin
          acc_d = qbit ? diff[63:0] : trial[63:0];
          a_d   = {a_q[62:0], qbit};
        end
        if (count_q == (w_q ? 6'd31 : 6'd63)) begin
          state_d = DONE;
          count_d = '0;
          if (mul_q) raw = acc_d;
          else if (rem_q) raw = negr_q ? -acc_d : acc_d;
          else raw = negq_q ? -a_d : a_d;
          result_d = w_q ? sext32(raw[31:0]) : raw;
        end else begin
          count_d = count_q + 6'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      count_d  = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      mul_q    <= 1'b0;
      w_q      <= 1'b0;
      rem_q    <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      mul_q    <= mul_d;
      w_q      <= w_d;
      rem_q    <= rem_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
    end
  end

  assign done   = (state_q == DONE);
  assign stall  = valid && !done;
  assign result = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq.
// Checks latency, stall, results, fast paths, flush and reset.
module tb_muldiv_seq;
  import common::*;

  logic       clk = 1'b0;
  logic       reset, valid, flush;
  decode_op_t op;
  word_t      srca, srcb;
  logic       stall, done;
  word_t      result;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk(clk), .reset(reset), .valid(valid), .op(op),
    .srca(srca), .srcb(srcb), .flush(flush),
    .stall(stall), .done(done), .result(result)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
  endtask

  task automatic run(input string tag, input decode_op_t o,
                     input word_t a, input word_t b,
                     input word_t exp, input int lat);
    int   c;
    logic stall_ok, seen;
    @(posedge clk); #1;
    op = o; srca = a; srcb = b; valid = 1'b1;
    c = 0; stall_ok = 1'b1; seen = 1'b0;
    while (c <= 200) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1'b1; break; end
      if (stall !== 1'b1) stall_ok = 1'b0;
      c++;
    end
    chk({tag, " done"}, 64'(seen), 64'd1);
    chk({tag, " latency"}, 64'(c), 64'(lat));
    chk({tag, " result"}, result, exp);
    chk({tag, " stall"}, 64'({stall_ok, stall}), 64'd2);
    @(posedge clk); #1;
    valid = 1'b0;
    srca = {$urandom, $urandom};
    srcb = {$urandom, $urandom};
    @(negedge clk);
    chk({tag, " hold"}, result, exp);
    chk({tag, " one-shot"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic ok;
    reset = 1'b1; valid = 1'b0; flush = 1'b0;
    op = '0; srca = '0; srcb = '0;
    @(negedge clk);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", result, 64'd0);
    chk("reset stall idle", 64'(stall), 64'd0);
    valid = 1'b1; op = OP_MUL; #1;
    chk("reset stall=valid", 64'(stall), 64'd1);
    valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    run("MUL -1*3", OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,
        64'hFFFF_FFFF_FFFF_FFFD, 65);
    run("DIVW -7/2", OP_DIVW, 64'h0000_0000_FFFF_FFF9, 64'd2,
        64'hFFFF_FFFF_FFFF_FFFD, 33);
    run("REMW -7%2", OP_REMW, 64'h0000_0000_FFFF_FFF9, 64'd2,
        64'hFFFF_FFFF_FFFF_FFFF, 33);
    run("DIVU /0", OP_DIVU, 64'd100, 64'd0,
        64'hFFFF_FFFF_FFFF_FFFF, 1);
    run("REMU /0", OP_REMU, 64'd100, 64'd0, 64'd100, 1);
    run("DIV ovf", OP_DIV, 64'h8000_0000_0000_0000,
        64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
    run("REM ovf", OP_REM, 64'h8000_0000_0000_0000,
        64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    run("DIVUW sext", OP_DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1,
        64'hFFFF_FFFF_FFFF_FFFF, 33);
    run("DIV -100/7", OP_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
        64'hFFFF_FFFF_FFFF_FFF2, 65);
    run("REM -100%7", OP_REM, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
        64'hFFFF_FFFF_FFFF_FFFE, 65);
    run("REMU 1000%7", OP_REMU, 64'd1000, 64'd7, 64'd6, 65);
    run("MULW", OP_MULW, 64'h0000_0000_7FFF_FFFF, 64'd2,
        64'hFFFF_FFFF_FFFF_FFFE, 33);
    run("DIVW ovf", OP_DIVW, 64'h0000_0000_8000_0000,
        64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run("REMUW /0", OP_REMUW, 64'h0000_0000_8000_0005, 64'd0,
        64'hFFFF_FFFF_8000_0005, 1);
    run("bad op", 8'hFF, 64'd5, 64'd3, 64'd0, 1);

    // valid and flush together in IDLE must not start the op
    @(posedge clk); #1;
    op = OP_DIVU; srca = 64'd5; srcb = 64'd0;
    valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush at capture", 64'(done), 64'd0);

    // flush mid-operation
    @(posedge clk); #1;
    op = OP_DIV; srca = 64'd1000; srcb = 64'd3;
    valid = 1'b1; ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || stall !== 1'b1) ok = 1'b0;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    if (done !== 1'b0) ok = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0; valid = 1'b0;
    @(negedge clk);
    chk("flush no done", 64'({ok, done}), 64'd2);
    run("MUL after flush", OP_MUL, 64'd6, 64'd7, 64'd42, 65);

    // reset mid-operation
    @(posedge clk); #1;
    op = OP_DIV; srca = 64'd1000; srcb = 64'd3;
    valid = 1'b1; ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("rst mid done", 64'({ok, done}), 64'd2);
    chk("rst mid result", result, 64'd0);
    chk("rst mid stall", 64'(stall), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0; valid = 1'b0;
    @(negedge clk);
    chk("rst recover idle", 64'(done), 64'd0);
    run("MUL after reset", OP_MUL, 64'd6, 64'd7, 64'd42, 65);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
